// File: rtl/interval_histogram_pkg.sv
// interval_pkg: shared types and helpers for the interval histogram stage.
//   hist_state_e : ACCUM (counting codes) / DRAIN (streaming bin results)
//   is_onehot()  : true when exactly one bit of a code is set
package interval_pkg;

  // Widest one-hot code the helper accepts; callers zero-extend to this.
  localparam int MAX_BINS = 64;

  typedef enum logic {ACCUM, DRAIN} hist_state_e;

  function automatic logic is_onehot(input logic [MAX_BINS-1:0] code);
    // x & (x-1) clears the lowest set bit; zero result means at most one bit.
    return (code != '0) && ((code & (code - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/interval_histogram_if.sv
// Stream interface of the interval histogram.
//   input side : in_valid_i / in_ready_o handshake carrying interval_i, in_last_i
//   output side: out_valid_o / out_ready_i handshake carrying out_bin_o,
//                out_count_o, out_last_o
// Modports: slave = histogram block, master = producer/consumer side.
interface interval_histogram_if #(
  parameter int NUM_BINS  = 8,
  parameter int CNT_WIDTH = 16,
  parameter int IDX_WIDTH = $clog2(NUM_BINS)
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [NUM_BINS-1:0]  interval_i;
  logic                 in_last_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [IDX_WIDTH-1:0] out_bin_o;
  logic [CNT_WIDTH-1:0] out_count_o;
  logic                 out_last_o;

  modport slave (
    input  in_valid_i, interval_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, out_bin_o, out_count_o, out_last_o
  );

  modport master (
    output in_valid_i, interval_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_bin_o, out_count_o, out_last_o
  );
endinterface

// File: rtl/interval_histogram_sat_counter.sv
// sat_counter: one histogram bin.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : synchronous clear (wins over inc_i)
//   inc_i         : increment request
//   cnt_o         : registered count, holds at all-ones
//   sat_o         : increment requested while already at all-ones
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 sat_o
);
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_full;

  assign w_full = &r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               r_cnt <= '0;
    else if (clr_i)            r_cnt <= '0;
    else if (inc_i && !w_full) r_cnt <= r_cnt + 1'b1;
  end

  assign cnt_o = r_cnt;
  assign sat_o = inc_i & w_full & ~clr_i;
endmodule

// File: rtl/interval_histogram.sv
// interval_histogram: counts one-hot interval codes per bin during a frame,
// then drains every bin count in order and re-arms.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : sync clear of counters, index, flags; aborts a drain
//   bus (slave)   : input code stream and output bin-result stream
//   bad_code_o    : sticky, a non-one-hot code was accepted
//   sat_o         : sticky, an increment hit a saturated bin
module interval_histogram
  import interval_pkg::*;
#(
  parameter  int NUM_BINS  = 8,
  parameter  int CNT_WIDTH = 16,
  localparam int IDX_WIDTH = $clog2(NUM_BINS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  interval_histogram_if.slave   bus,
  output logic                  bad_code_o,
  output logic                  sat_o
);
  hist_state_e r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0] r_idx, w_idx_nxt;

  logic [NUM_BINS-1:0][CNT_WIDTH-1:0] w_cnt;
  logic [NUM_BINS-1:0]                w_inc, w_clr, w_sat;

  logic w_in_hs, w_out_hs, w_onehot, w_idx_last;

  assign w_in_hs    = (r_state == ACCUM) & bus.in_valid_i;
  assign w_out_hs   = (r_state == DRAIN) & bus.out_ready_i;
  assign w_onehot   = is_onehot(MAX_BINS'(bus.interval_i));
  assign w_idx_last = (r_idx == IDX_WIDTH'(NUM_BINS-1));

  // State / drain index
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ACCUM;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (clear_i) begin
      w_state_nxt = ACCUM;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ACCUM: if (w_in_hs && bus.in_last_i) begin
          w_state_nxt = DRAIN;
          w_idx_nxt   = '0;
        end
        DRAIN: if (w_out_hs) begin
          if (w_idx_last) begin
            w_state_nxt = ACCUM;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
        default: w_state_nxt = ACCUM;
      endcase
    end
  end

  // Bins: increment on accepted one-hot code, clear when drained out.
  for (genvar g = 0; g < NUM_BINS; g++) begin : g_bin
    assign w_inc[g] = w_in_hs & ~clear_i & w_onehot & bus.interval_i[g];
    assign w_clr[g] = clear_i | (w_out_hs & (r_idx == IDX_WIDTH'(g)));

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (w_clr[g]),
      .inc_i  (w_inc[g]),
      .cnt_o  (w_cnt[g]),
      .sat_o  (w_sat[g])
    );
  end

  // Sticky flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bad_code_o <= 1'b0;
      sat_o      <= 1'b0;
    end else if (clear_i) begin
      bad_code_o <= 1'b0;
      sat_o      <= 1'b0;
    end else begin
      if (w_in_hs && !w_onehot) bad_code_o <= 1'b1;
      if (|w_sat)               sat_o      <= 1'b1;
    end
  end

  // Outputs decode only state, index and counter registers.
  assign bus.in_ready_o  = (r_state == ACCUM);
  assign bus.out_valid_o = (r_state == DRAIN);
  assign bus.out_bin_o   = r_idx;
  assign bus.out_count_o = (r_state == DRAIN) ? w_cnt[r_idx] : '0;
  assign bus.out_last_o  = (r_state == DRAIN) & w_idx_last;
endmodule

// File: tb/tb_interval_histogram.sv
module tb_interval_histogram;
  localparam int NB = 8;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic bad, sat;

  interval_histogram_if #(.NUM_BINS(NB), .CNT_WIDTH(CW)) bus ();

  interval_histogram #(.NUM_BINS(NB), .CNT_WIDTH(CW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear),
    .bus        (bus),
    .bad_code_o (bad),
    .sat_o      (sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: per-bin counts plus frame/drain position.
  int mcnt[NB];
  bit mbad, msat, mdrain;
  int midx;

  typedef struct { logic [NB-1:0] code; bit last; } vec_t;
  typedef struct { int bin; int count; bit last; } drn_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) mcnt[i] = 0;
    mbad = 0; msat = 0; mdrain = 0; midx = 0;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".in_ready"},  int'(bus.in_ready_o),  int'(!mdrain));
    chk({tag, ".out_valid"}, int'(bus.out_valid_o), int'(mdrain));
    chk({tag, ".out_bin"},   int'(bus.out_bin_o),   midx);
    chk({tag, ".out_count"}, int'(bus.out_count_o), mdrain ? mcnt[midx] : 0);
    chk({tag, ".out_last"},  int'(bus.out_last_o),  int'(mdrain && midx == NB-1));
    chk({tag, ".bad"},       int'(bad),             int'(mbad));
    chk({tag, ".sat"},       int'(sat),             int'(msat));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic step(input bit v, input logic [NB-1:0] code, input bit last,
                      input bit rdy, input bit clr, input string tag);
    bus.in_valid_i  = v;
    bus.interval_i  = code;
    bus.in_last_i   = last;
    bus.out_ready_i = rdy;
    clear           = clr;
    @(posedge clk);
    #1;
    if (clr) begin
      model_reset();
    end else if (!mdrain) begin
      if (v) begin
        if ($countones(code) == 1) begin
          for (int b = 0; b < NB; b++)
            if (code[b]) begin
              if (mcnt[b] == MAXC) msat = 1;
              else mcnt[b]++;
            end
        end else begin
          mbad = 1;
        end
        if (last) begin mdrain = 1; midx = 0; end
      end
    end else if (rdy) begin
      mcnt[midx] = 0;
      if (midx == NB-1) begin mdrain = 0; midx = 0; end
      else midx++;
    end
    bus.in_valid_i  = 0;
    bus.out_ready_i = 0;
    clear           = 0;
    chk_out(tag);
  endtask

  task automatic send(input logic [NB-1:0] code, input bit last);
    step(1, code, last, 0, 0, "send");
  endtask

  task automatic drain_all();
    for (int i = 0; i < NB; i++) step(0, '0, 0, 1, 0, "drain");
  endtask

  vec_t basic[4];
  drn_t exp_drn[NB];

  initial begin
    rst_n = 0; clear = 0;
    bus.in_valid_i = 0; bus.interval_i = '0; bus.in_last_i = 0; bus.out_ready_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.in_ready", int'(bus.in_ready_o), 1);
    chk("reset.out_valid", int'(bus.out_valid_o), 0);
    chk("reset.out_count", int'(bus.out_count_o), 0);
    chk_out("reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // Basic frame, table driven.
    basic[0] = '{8'h01, 0}; basic[1] = '{8'h04, 0};
    basic[2] = '{8'h04, 0}; basic[3] = '{8'h80, 1};
    exp_drn[0] = '{0, 1, 0}; exp_drn[1] = '{1, 0, 0}; exp_drn[2] = '{2, 2, 0};
    exp_drn[3] = '{3, 0, 0}; exp_drn[4] = '{4, 0, 0}; exp_drn[5] = '{5, 0, 0};
    exp_drn[6] = '{6, 0, 0}; exp_drn[7] = '{7, 1, 1};
    for (int i = 0; i < 4; i++) send(basic[i].code, basic[i].last);
    for (int i = 0; i < NB; i++) begin
      chk("basic.valid", int'(bus.out_valid_o), 1);
      chk("basic.bin",   int'(bus.out_bin_o),   exp_drn[i].bin);
      chk("basic.count", int'(bus.out_count_o), exp_drn[i].count);
      chk("basic.last",  int'(bus.out_last_o),  int'(exp_drn[i].last));
      step(0, '0, 0, 1, 0, "basic_drain");
    end
    chk("basic.rearm", int'(bus.in_ready_o), 1);

    // Second frame: only bin 1 counts; drained bins were cleared.
    send(8'h02, 1);
    for (int i = 0; i < NB; i++) begin
      chk("frame2.count", int'(bus.out_count_o), (i == 1) ? 1 : 0);
      step(0, '0, 0, 1, 0, "frame2_drain");
    end

    // Backpressure at bin 2.
    send(8'h04, 0); send(8'h04, 0); send(8'h04, 1);
    step(0, '0, 0, 1, 0, "bp"); step(0, '0, 0, 1, 0, "bp");
    for (int i = 0; i < 5; i++) begin
      step(0, '0, 0, 0, 0, "bp_hold");
      chk("bp.bin", int'(bus.out_bin_o), 2);
      chk("bp.count", int'(bus.out_count_o), 3);
      chk("bp.in_ready", int'(bus.in_ready_o), 0);
    end
    for (int i = 2; i < NB; i++) step(0, '0, 0, 1, 0, "bp_resume");

    // Bad codes.
    send(8'h00, 0); send(8'h03, 0); send(8'h10, 1);
    chk("bad.flag", int'(bad), 1);
    for (int i = 0; i < NB; i++) begin
      chk("bad.count", int'(bus.out_count_o), (i == 4) ? 1 : 0);
      step(0, '0, 0, 1, 0, "bad_drain");
    end
    chk("bad.sticky", int'(bad), 1);

    // Saturation: 20 codes into bin 0.
    for (int i = 0; i < 20; i++) send(8'h01, i == 19);
    chk("sat.count", int'(bus.out_count_o), 15);
    chk("sat.flag", int'(sat), 1);
    drain_all();

    // Clear on the bin 3 handshake.
    send(8'h00, 0); send(8'h08, 0); send(8'h08, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1, 0, "clr_pre");
    step(0, '0, 0, 1, 1, "clr");
    chk("clr.in_ready", int'(bus.in_ready_o), 1);
    chk("clr.out_valid", int'(bus.out_valid_o), 0);
    chk("clr.bad", int'(bad), 0);
    chk("clr.sat", int'(sat), 0);
    send(8'h02, 1);
    for (int i = 0; i < NB; i++) begin
      chk("clr_post.count", int'(bus.out_count_o), (i == 1) ? 1 : 0);
      step(0, '0, 0, 1, 0, "clr_post");
    end

    // Reset mid-drain, checked before the next clock edge.
    send(8'h00, 0); send(8'h04, 1);
    step(0, '0, 0, 1, 0, "rst_pre"); step(0, '0, 0, 1, 0, "rst_pre");
    rst_n = 0;
    #1;
    model_reset();
    chk("rst.out_valid", int'(bus.out_valid_o), 0);
    chk("rst.in_ready", int'(bus.in_ready_o), 1);
    chk("rst.out_bin", int'(bus.out_bin_o), 0);
    chk("rst.out_count", int'(bus.out_count_o), 0);
    chk("rst.bad", int'(bad), 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk_out("rst_post");
    send(8'h04, 1);
    for (int i = 0; i < NB; i++) begin
      chk("rst_post.count", int'(bus.out_count_o), (i == 2) ? 1 : 0);
      step(0, '0, 0, 1, 0, "rst_drain");
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      logic [NB-1:0] code;
      logic [7:0] r;
      r = 8'($urandom);
      code = (($urandom % 5) == 0) ? NB'($urandom) : NB'(1 << ($urandom % NB));
      step(($urandom % 4) != 0, code, ($urandom % 12) == 0, ($urandom % 3) != 0,
           r == 8'd7, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
